// File: rtl/imem_load_if.sv
// Bundle of the handshake and IMEM/core-control signals around the
// program-download sequencer. The master side feeds words in; the
// slave side (the sequencer) drives the IMEM write port and status.
interface imem_load_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [31:0]       word_in;
    logic              word_vld;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_cnt;

    modport master (
        output start, word_in, word_vld,
        input  imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, err, word_cnt
    );

    modport slave (
        input  start, word_in, word_vld,
        output imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, err, word_cnt
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Program-download sequencer: validates a header word, streams the
// payload into consecutive IMEM word addresses, verifies a trailing
// additive checksum and releases the core from reset only on success.
module imem_load_ctrl #(
    parameter int          ADDR_W      = 10,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter logic [15:0] MAGIC       = 16'hB007
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_load_if.slave  bus
);

    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_ONE   = TW'(32'd1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Running payload checksum: plain 32-bit sum that wraps.
    function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] w);
        return acc + w;
    endfunction

    state_t            state_r, state_s;
    logic [CW-1:0]     len_r, len_s;
    logic [31:0]       csum_r, csum_s;
    logic [TW-1:0]     tmo_r, tmo_s;
    logic [CW-1:0]     word_cnt_r, word_cnt_s;
    logic              imem_we_r, imem_we_s;
    logic [ADDR_W-1:0] imem_addr_r, imem_addr_s;
    logic [31:0]       imem_wdata_r, imem_wdata_s;
    logic              busy_r, done_r, err_r, cpu_rst_n_r;

    logic [15:0]       hdr_len_s;
    logic              hdr_bad_s;
    logic              tmo_hit_s;

    assign hdr_len_s = bus.word_in[15:0];
    assign hdr_bad_s = (bus.word_in[31:16] != MAGIC) ||
                       (hdr_len_s == 16'h0000) ||
                       ({1'b0, hdr_len_s} > MAX_WORDS);
    assign tmo_hit_s = (tmo_r == TMO_LIMIT);

    // Next-state and datapath decode; the write strobe is a one-cycle pulse by default.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        csum_s       = csum_r;
        tmo_s        = tmo_r;
        word_cnt_s   = word_cnt_r;
        imem_we_s    = 1'b0;
        imem_addr_s  = imem_addr_r;
        imem_wdata_s = imem_wdata_r;

        case (state_r)
            IDLE, DONE, ERR: begin
                // A word arriving together with start is dropped.
                if (bus.start) begin
                    state_s     = HDR;
                    word_cnt_s  = {CW{1'b0}};
                    imem_addr_s = {ADDR_W{1'b0}};
                    csum_s      = 32'h0000_0000;
                    tmo_s       = {TW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            HDR: begin
                if (bus.word_vld) begin
                    tmo_s = {TW{1'b0}};
                    if (hdr_bad_s) begin
                        state_s = ERR;
                    end else begin
                        len_s   = CW'(hdr_len_s);
                        state_s = LOAD;
                    end
                end else if (tmo_hit_s) begin
                    state_s = ERR;
                end else begin
                    tmo_s = tmo_r + TMO_ONE;
                end
            end
            LOAD: begin
                if (bus.word_vld) begin
                    tmo_s        = {TW{1'b0}};
                    imem_we_s    = 1'b1;
                    imem_addr_s  = word_cnt_r[ADDR_W-1:0];
                    imem_wdata_s = bus.word_in;
                    csum_s       = csum_add(csum_r, bus.word_in);
                    word_cnt_s   = word_cnt_r + CNT_ONE;
                    if ((word_cnt_r + CNT_ONE) == len_r) begin
                        state_s = CHK;
                    end else begin
                        state_s = LOAD;
                    end
                end else if (tmo_hit_s) begin
                    state_s = ERR;
                end else begin
                    tmo_s = tmo_r + TMO_ONE;
                end
            end
            CHK: begin
                if (bus.word_vld) begin
                    tmo_s = {TW{1'b0}};
                    if (bus.word_in == csum_r) begin
                        state_s = DONE;
                    end else begin
                        state_s = ERR;
                    end
                end else if (tmo_hit_s) begin
                    state_s = ERR;
                end else begin
                    tmo_s = tmo_r + TMO_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            len_r        <= {CW{1'b0}};
            csum_r       <= 32'h0000_0000;
            tmo_r        <= {TW{1'b0}};
            word_cnt_r   <= {CW{1'b0}};
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= 32'h0000_0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cpu_rst_n_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            csum_r       <= csum_s;
            tmo_r        <= tmo_s;
            word_cnt_r   <= word_cnt_s;
            imem_we_r    <= imem_we_s;
            imem_addr_r  <= imem_addr_s;
            imem_wdata_r <= imem_wdata_s;
            busy_r       <= (state_s == HDR) || (state_s == LOAD) || (state_s == CHK);
            done_r       <= (state_s == DONE);
            err_r        <= (state_s == ERR);
            // Core only runs after a fully verified load.
            cpu_rst_n_r  <= (state_s == DONE);
        end
    end

    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign bus.cpu_rst_n  = cpu_rst_n_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.word_cnt   = word_cnt_r;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl. Expected IMEM writes are
// queued as payload words are driven and popped by a write monitor.
module tb_imem_load_ctrl;

    localparam int AW   = 10;
    localparam int TMO  = 64;
    localparam int MAXW = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    imem_load_if #(.ADDR_W(AW)) bus ();

    imem_load_ctrl #(
        .ADDR_W(AW),
        .TIMEOUT_CYC(TMO),
        .MAGIC(16'hB007)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    // Write monitor: every IMEM strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL imem_write: unexpected write addr=%0d data=%h, expected none", bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.imem_addr !== mon_e.addr || bus.imem_wdata !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL imem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             bus.imem_addr, bus.imem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    // Run-time bound so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.word_in  = w;
        bus.word_vld = 1'b1;
        @(posedge clk); #1;
        bus.word_vld = 1'b0;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] w);
        exp_q.push_back('{addr: a, data: w});
        send_word(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.word_vld = 1'b0; bus.word_in = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.err} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.err});
        end
        n_checks++;
        if (bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'h0 || bus.word_cnt !== 11'd0) begin
            n_fail++; $display("FAIL reset_data: got addr=%0d data=%h cnt=%0d expected 0/0/0", bus.imem_addr, bus.imem_wdata, bus.word_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        send_word(32'hB007_0001);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL idle_word_ignored: got busy=%b err=%b expected 0/0", bus.busy, bus.err);
        end
    endtask

    task automatic test_nominal();
        pulse_start();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.cpu_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL start_to_hdr: got busy=%b done=%b err=%b cpu_rst_n=%b expected 1/0/0/0", bus.busy, bus.done, bus.err, bus.cpu_rst_n);
        end
        send_word(32'hB007_0003);
        load_word(10'd0, 32'd1);
        load_word(10'd1, 32'd2);
        load_word(10'd2, 32'd3);
        n_checks++;
        if (bus.word_cnt !== 11'd3 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL nominal_payload: got cnt=%0d busy=%b done=%b expected 3/1/0", bus.word_cnt, bus.busy, bus.done);
        end
        send_word(32'd6);
        n_checks++;
        if (bus.done !== 1'b1 || bus.cpu_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.word_cnt !== 11'd3) begin
            n_fail++; $display("FAIL nominal_done: got done=%b cpu_rst_n=%b busy=%b err=%b cnt=%0d expected 1/1/0/0/3",
                               bus.done, bus.cpu_rst_n, bus.busy, bus.err, bus.word_cnt);
        end
    endtask

    task automatic test_bad_header();
        pulse_start();
        n_checks++;
        if (bus.done !== 1'b0 || bus.cpu_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL restart_clears_done: got done=%b cpu_rst_n=%b expected 0/0", bus.done, bus.cpu_rst_n);
        end
        send_word(32'hDEAD_0004);
        n_checks++;
        if (bus.err !== 1'b1 || bus.cpu_rst_n !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL bad_magic: got err=%b cpu_rst_n=%b busy=%b done=%b expected 1/0/0/0", bus.err, bus.cpu_rst_n, bus.busy, bus.done);
        end
        pulse_start();
        send_word(32'hB007_0001);
        load_word(10'd0, 32'h0000_0007);
        send_word(32'h0000_0007);
        n_checks++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.cpu_rst_n !== 1'b1) begin
            n_fail++; $display("FAIL recover_after_err: got done=%b err=%b cpu_rst_n=%b expected 1/0/1", bus.done, bus.err, bus.cpu_rst_n);
        end
    endtask

    task automatic test_length_bounds();
        logic [31:0] sum;
        logic [31:0] w;
        pulse_start();
        send_word(32'hB007_0000);
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL len_zero: got err=%b expected 1", bus.err);
        end
        pulse_start();
        send_word({16'hB007, 16'(MAXW + 1)});
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL len_too_big: got err=%b expected 1", bus.err);
        end
        pulse_start();
        send_word({16'hB007, 16'(MAXW)});
        sum = 32'h0;
        for (int i = 0; i < MAXW; i++) begin
            w = (32'(i) * 32'h9E37_79B9) + 32'h0000_0001;
            sum = sum + w;
            load_word(AW'(i), w);
        end
        n_checks++;
        if (bus.word_cnt !== 11'(MAXW) || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL len_max_count: got cnt=%0d busy=%b expected %0d/1", bus.word_cnt, bus.busy, MAXW);
        end
        send_word(sum);
        n_checks++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL len_max_done: got done=%b err=%b expected 1/0", bus.done, bus.err);
        end
    endtask

    task automatic test_checksum();
        pulse_start();
        send_word(32'hB007_0002);
        load_word(10'd0, 32'hFFFF_FFFF);
        load_word(10'd1, 32'h0000_0002);
        send_word(32'h0000_0001);
        n_checks++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL csum_wrap_ok: got done=%b err=%b expected 1/0", bus.done, bus.err);
        end
        pulse_start();
        send_word(32'hB007_0002);
        load_word(10'd0, 32'hFFFF_FFFF);
        load_word(10'd1, 32'h0000_0002);
        send_word(32'h0000_0000);
        n_checks++;
        if (bus.done !== 1'b0 || bus.err !== 1'b1 || bus.cpu_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL csum_bad: got done=%b err=%b cpu_rst_n=%b expected 0/1/0", bus.done, bus.err, bus.cpu_rst_n);
        end
    endtask

    task automatic test_timeout_reset();
        pulse_start();
        send_word(32'hB007_0002);
        load_word(10'd0, 32'h1234_5678);
        repeat (TMO) @(posedge clk);
        #1;
        n_checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early: got err=%b busy=%b expected 0/1", bus.err, bus.busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err: got err=%b busy=%b cpu_rst_n=%b expected 1/0/0", bus.err, bus.busy, bus.cpu_rst_n);
        end
        pulse_start();
        send_word(32'hB007_0004);
        load_word(10'd0, 32'hAAAA_0001);
        load_word(10'd1, 32'hAAAA_0002);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.err} !== 5'b00000 ||
            bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'h0 || bus.word_cnt !== 11'd0) begin
            n_fail++; $display("FAIL async_reset: got flags=%b addr=%0d data=%h cnt=%0d expected 00000/0/0/0",
                               {bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.err}, bus.imem_addr, bus.imem_wdata, bus.word_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_word(32'hAAAA_0003);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.word_cnt !== 11'd0) begin
            n_fail++; $display("FAIL reset_to_idle: got busy=%b err=%b cnt=%0d expected 0/0/0", bus.busy, bus.err, bus.word_cnt);
        end
    endtask

    task automatic test_collisions();
        bus.start    = 1'b1;
        bus.word_in  = 32'hB007_0001;
        bus.word_vld = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.word_vld = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL start_word_collide: got busy=%b expected 1", bus.busy);
        end
        send_word(32'hB007_0002);
        load_word(10'd0, 32'd5);
        load_word(10'd1, 32'd6);
        send_word(32'd11);
        n_checks++;
        if (bus.done !== 1'b1 || bus.word_cnt !== 11'd2) begin
            n_fail++; $display("FAIL collide_dropped_word: got done=%b cnt=%0d expected 1/2", bus.done, bus.word_cnt);
        end
        pulse_start();
        send_word(32'hB007_0003);
        load_word(10'd0, 32'd10);
        pulse_start();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.word_cnt !== 11'd1) begin
            n_fail++; $display("FAIL start_in_load: got busy=%b cnt=%0d expected 1/1", bus.busy, bus.word_cnt);
        end
        load_word(10'd1, 32'd20);
        load_word(10'd2, 32'd30);
        send_word(32'd60);
        n_checks++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.word_cnt !== 11'd3) begin
            n_fail++; $display("FAIL start_in_load_done: got done=%b err=%b cnt=%0d expected 1/0/3", bus.done, bus.err, bus.word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_header();
        test_length_bounds();
        test_checksum();
        test_timeout_reset();
        test_collisions();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL write_queue_drained: got %0d pending writes expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
